// File: rtl/imem_port_arbiter_pkg.sv
// imem_port_arbiter_pkg: state encoding and word-offset constant shared by the arbiter files.
package imem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;
  localparam int WORD_OFFSET = 2;
endpackage

// File: rtl/imem_arb_pick.sv
// imem_arb_pick: combinational grant select between two requesters.
// IMEM_ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise port 0 wins.
module imem_arb_pick (
  input  logic i_req0_valid,
  input  logic i_req1_valid,
`ifdef IMEM_ARB_ROUND_ROBIN_EN
  input  logic i_last,
`endif
  output logic o_any,
  output logic o_sel
);
  assign o_any = i_req0_valid | i_req1_valid;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
  assign o_sel = (i_req0_valid & i_req1_valid) ? ~i_last : i_req1_valid;
`else
  assign o_sel = i_req1_valid & ~i_req0_valid;
`endif
endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: two-port instruction-memory arbiter with registered responses and backpressure.
// IMEM_ARB_ROUND_ROBIN_EN enables round-robin tie breaking (default fixed priority to port 0).
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_err,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_addr, w_addr;
  logic                  w_free, w_any, w_sel, w_gnt, w_err;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
  logic                  r_last;
`endif
  // a slot is free when idle or when the pending response handshakes this cycle
  assign w_free = !reset && (r_state == IDLE || (r_state == BUSY0 && rsp0_ready) ||
                             (r_state == BUSY1 && rsp1_ready));
  imem_arb_pick u_pick (
    .i_req0_valid(req0_valid),
    .i_req1_valid(req1_valid),
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    .i_last      (r_last),
`endif
    .o_any       (w_any),
    .o_sel       (w_sel)
  );
  assign w_gnt      = w_free & w_any;
  assign w_addr     = w_sel ? req1_addr : req0_addr;
  assign w_err      = (|w_addr[WORD_OFFSET-1:0]) ||
                      ((w_addr >> WORD_OFFSET) >= DATA_WIDTH'(MEMORY_DEPTH));
  assign req0_ready = w_gnt & ~w_sel;
  assign req1_ready = w_gnt & w_sel;
  assign mem_addr   = w_gnt ? w_addr : r_addr;
  assign rsp0_valid = r_state == BUSY0;
  assign rsp1_valid = r_state == BUSY1;
  always_comb w_next = w_gnt ? (w_sel ? BUSY1 : BUSY0) : (w_free ? IDLE : r_state);
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      rsp0_data <= '0;
      rsp1_data <= '0;
      rsp0_err  <= 1'b0;
      rsp1_err  <= 1'b0;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      r_last    <= 1'b1;
`endif
    end else if (w_gnt) begin
      r_addr <= w_addr;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      r_last <= w_sel;
`endif
      if (w_sel) begin
        rsp1_data <= w_err ? '0 : mem_rdata;
        rsp1_err  <= w_err;
      end else begin
        rsp0_data <= w_err ? '0 : mem_rdata;
        rsp0_err  <= w_err;
      end
    end
  end
endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the address and data width.
REQ-002 The block SHALL have parameter MEMORY_DEPTH, default 1024, which is the word count of the program memory.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, synchronous and active-high.
REQ-005 Ports req0_valid and req1_valid SHALL be inputs, 1 bit wide, and each asserts a read request.
REQ-006 Ports req0_addr and req1_addr SHALL be inputs, DATA_WIDTH wide, and carry byte addresses.
REQ-007 Ports req0_ready and req1_ready SHALL be outputs, 1 bit wide, and each marks the request accepted in that cycle.
REQ-008 Ports rsp0_valid and rsp1_valid SHALL be outputs, 1 bit wide, and each marks response data valid.
REQ-009 Ports rsp0_ready and rsp1_ready SHALL be inputs, 1 bit wide, and each marks the consumer accepting the response.
REQ-010 Ports rsp0_data and rsp1_data SHALL be outputs, DATA_WIDTH wide, and carry the instruction word.
REQ-011 Ports rsp0_err and rsp1_err SHALL be outputs, 1 bit wide, and flag a misaligned or out-of-range address.
REQ-012 Port mem_addr SHALL be an output, DATA_WIDTH wide, and drives the program memory byte address.
REQ-013 Port mem_rdata SHALL be an input, DATA_WIDTH wide, and receives the combinational read data from program memory.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY0 and BUSY1; BUSYn means a response is pending on port n.
REQ-015 A grant SHALL be allowed in IDLE, or in BUSYn in the cycle where rspn_valid and rspn_ready are both high (back-to-back operation).
REQ-016 On a grant to port n, reqn_ready SHALL be 1 in that cycle, and mem_addr SHALL equal reqn_addr combinationally in the same cycle.
REQ-017 The granted mem_rdata SHALL be registered into rspn_data; rspn_valid SHALL rise on the next edge (1-cycle latency); the state SHALL move to BUSYn.
REQ-018 When no grant occurs, mem_addr SHALL hold the last granted address.
REQ-019 rspn_valid, rspn_data and rspn_err SHALL stay stable while rspn_ready is low (backpressure); no new grant SHALL occur while a response is held.
REQ-020 When a response handshakes with no new grant, rspn_valid SHALL drop on the next edge and the state SHALL return to IDLE.
REQ-021 The error condition SHALL be addr[1:0] != 0 or addr[DATA_WIDTH-1:2] >= MEMORY_DEPTH; on error, rspn_err SHALL be 1 and rspn_data SHALL be 0, with the same latency as a normal response.
REQ-022 When only one request is valid, that request SHALL be granted.
REQ-023 When both requests are valid, the port SHALL be chosen per REQ-029/REQ-030.
REQ-024 At most one ready signal SHALL be high per cycle, and at most one rsp_valid SHALL be high at any time.
REQ-025 A requester SHALL hold valid and addr stable until ready; the arbiter SHALL not latch an address without ready.

Reset
REQ-026 On reset, the state SHALL be IDLE, all rsp_valid, rsp_err, ready and rsp_data outputs SHALL be 0, mem_addr SHALL be 0, and the last-grant pointer SHALL be 1.
REQ-027 Reset asserted mid-transaction SHALL discard the pending response with no handshake; the first grant after reset SHALL occur no earlier than the first cycle with reset low.
REQ-028 Reset SHALL take priority over any simultaneous request or response handshake.

Configuration
REQ-029 With IMEM_ARB_ROUND_ROBIN_EN defined, a tie SHALL be granted to the port not granted last, and the last-grant pointer SHALL update on every grant.
REQ-030 Without IMEM_ARB_ROUND_ROBIN_EN, port 0 SHALL always win a tie (fixed priority), and the pointer logic SHALL be absent.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, BUSY0=2'd1, BUSY1=2'd2) and the word-offset constant 2.
REQ-032 A single sub-module, imem_arb_pick, SHALL implement the combinational grant select (fixed or round-robin); the FSM and response registers SHALL stay in the top module.

Verification
REQ-033 Single request: port 0 requests 0x00000008 with mem_rdata=0x20080005 -> req0_ready=1 in cycle 0, rsp0_valid=1 and rsp0_data=0x20080005 in cycle 1, rsp0_err=0.
REQ-034 Tie with round-robin: both ports request continuously with rsp_ready=1 -> grants go 0,1,0,1 on back-to-back cycles with no idle cycle. Without the macro, grants go 0,0,0,0.
REQ-035 Backpressure: rsp1_ready=0 for 3 cycles after a grant -> rsp1_valid and rsp1_data hold, req0_ready stays 0, and the grant resumes in the cycle rsp1_ready=1.
REQ-036 Error addresses: address 0x00000006 -> rsp_err=1 and data=0. Address 0x00001000 with MEMORY_DEPTH=1024 -> rsp_err=1. Address 0x00000FFC -> rsp_err=0.
REQ-037 Reset mid-operation: assert reset while in BUSY0 -> next edge gives rsp0_valid=0, state IDLE, mem_addr=0, and a pending req1 is granted in the first cycle after reset falls.
